// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side adapter for a simple dual-port-RAM FIFO whose read port has one
// cycle of latency. Words are pulled with fifo_read, captured the following
// cycle from fifo_read_data, and presented on a valid/ready output stream
// at full throughput. A two-entry circular buffer holds captured words so a
// read that is already in flight when the consumer stalls always has a slot.
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid is high, out_valid and out_data
// hold steady until that transfer happens. out_ready is a don't-care while
// out_valid is low.
//
// Ports
//   clk             single clock, rising edge
//   reset           asynchronous, active-low reset
//   fifo_empty      FIFO empty flag
//   fifo_read       FIFO read strobe (combinational)
//   fifo_read_data  FIFO read data, valid the cycle after fifo_read
//   flush           synchronous discard of buffered and in-flight words
//   out_valid       out_data holds a word (registered)
//   out_data        head word (registered)
//   out_ready       consumer accepts the word
//   word_count      16-bit transfer counter, wraps; only when the macro
//                   FIFO_STREAM_READER_CNT_EN is defined
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int FIFO_DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fifo_empty,
    output logic                       fifo_read,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_read_data,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [FIFO_DATA_WIDTH-1:0] out_data,
    input  logic                       out_ready
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [15:0]                word_count
`endif
);

    // Buffer storage and bookkeeping
    logic [FIFO_DATA_WIDTH-1:0] buf0_q;
    logic [FIFO_DATA_WIDTH-1:0] buf1_q;
    logic                       head_q;
    logic [1:0]                 cnt_q;
    logic                       inflight_q;
    logic                       out_valid_q;
    logic [FIFO_DATA_WIDTH-1:0] out_data_q;

    // Next-state values
    logic [FIFO_DATA_WIDTH-1:0] nxt_buf0;
    logic [FIFO_DATA_WIDTH-1:0] nxt_buf1;
    logic                       nxt_head;
    logic [1:0]                 nxt_cnt;
    logic                       tail;
    logic                       pop;
    logic [2:0]                 occ;

    assign pop = out_valid_q & out_ready;

    // Slots that will be claimed after this edge: stored words plus the
    // word arriving from the FIFO, minus the word leaving. pop implies
    // cnt_q >= 1, so this never underflows.
    assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Issue a read only if its word is guaranteed a slot when it lands.
    assign fifo_read = reset & ~flush & ~fifo_empty & (occ < 3'd2);

    // With a word in flight cnt_q is at most 1, so the tail is head or
    // head+1 and never collides with the entry being popped.
    assign tail = head_q ^ cnt_q[0];

    always_comb begin
        nxt_buf0 = buf0_q;
        nxt_buf1 = buf1_q;
        nxt_head = head_q ^ pop;
        nxt_cnt  = occ[1:0];
        if (inflight_q && !flush) begin
            if (tail) begin
                nxt_buf1 = fifo_read_data;
            end else begin
                nxt_buf0 = fifo_read_data;
            end
        end
        if (flush) begin
            nxt_head = 1'b0;
            nxt_cnt  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf0_q      <= '0;
            buf1_q      <= '0;
            head_q      <= 1'b0;
            cnt_q       <= 2'd0;
            inflight_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            buf0_q      <= nxt_buf0;
            buf1_q      <= nxt_buf1;
            head_q      <= nxt_head;
            cnt_q       <= nxt_cnt;
            inflight_q  <= fifo_read;
            // Outputs are registered copies of the next head entry so the
            // consumer sees clean flop outputs.
            out_valid_q <= (nxt_cnt != 2'd0);
            out_data_q  <= nxt_head ? nxt_buf1 : nxt_buf0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [15:0] word_count_q;

    // Counts every transfer, including one in a flush cycle; only reset
    // clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count_q <= 16'd0;
        end else if (pop) begin
            word_count_q <= word_count_q + 16'd1;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Directed bench for fifo_stream_reader. A small behavioural FIFO with one
// cycle of read latency feeds the DUT; the stimulus is one linear sequence
// of steps with hand-computed expected values checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fifo_empty;
  logic         fifo_read;
  logic [W-1:0] fifo_read_data = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [15:0]  word_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  fifo_stream_reader #(.FIFO_DATA_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_read      (fifo_read),
    .fifo_read_data (fifo_read_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready)
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    .word_count     (word_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Behavioural source FIFO: words are written by the stimulus, read data
  // appears the cycle after fifo_read. rd_cnt counts every read strobe.
  // ---------------------------------------------------------------------------
  logic [W-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_read) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_ptr != wr_ptr) begin
        fifo_read_data <= mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comparison
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int base, input int n, input logic [W-1:0] first);
    logic [W-1:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      mem[(base + i) % 256] = v;
      v = v + 8'd1;
    end
    wr_ptr = base + n;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int rd0;

  initial begin
    // ---- reset state, FIFO already holding 5 words --------------------------
    load(0, 5, 8'h00);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_read", fifo_read, 0);

    // ---- reset then stream 0x00..0x04 -----------------------------------------
    reset = 1'b1;
    rd0 = rd_cnt;
    #1 chk("t1_read_c0", fifo_read, 1);
    @(negedge clk);
    chk("t1_valid_c1", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, i);
    end
    @(negedge clk);
    chk("t1_valid_end", out_valid, 0);
    chk("t1_reads", rd_cnt - rd0, 5);

    // ---- back-pressure: 10 words, out_ready low for 8 cycles ------------------
    out_ready = 1'b0;
    load(5, 10, 8'h10);
    rd0 = rd_cnt;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_hold_data", out_data, 8'h10);
      end
    end
    chk("t2_reads_stalled", rd_cnt - rd0, 2);
    chk("t2_read_idle", fifo_read, 0);
    out_ready = 1'b1;
    #1 chk("t2_read_restart", fifo_read, 1);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, 8'h10 + j);
    end
    @(negedge clk);
    chk("t2_valid_end", out_valid, 0);
    chk("t2_reads_total", rd_cnt - rd0, 10);

    // ---- alternating out_ready with a non-empty FIFO -------------------------
    out_ready = 1'b0;
    load(15, 16, 8'h20);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      out_ready = 1'b1;
      chk("t3_alt_valid", out_valid, 1);
      chk("t3_alt_data", out_data, 8'h20 + k);
      @(negedge clk);
      out_ready = 1'b0;
      chk("t3_alt_hold", out_data, 8'h21 + k);
      @(negedge clk);
    end
    for (int k = 8; k < 16; k++) begin
      out_ready = 1'b1;
      chk("t3_drain_valid", out_valid, 1);
      chk("t3_drain_data", out_data, 8'h20 + k);
      @(negedge clk);
    end
    chk("t3_valid_end", out_valid, 0);

    // ---- flush with a read in flight ------------------------------------------
    out_ready = 1'b0;
    load(31, 4, 8'h40);
    rd0 = rd_cnt;
    @(negedge clk);
    flush = 1'b1;
    #1 chk("t4_read_forced_low", fifo_read, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("t4_valid_after_flush", out_valid, 0);
    #1 chk("t4_read_resume", fifo_read, 1);
    @(negedge clk);
    chk("t4_valid_gap", out_valid, 0);
    @(negedge clk);
    chk("t4_valid_first", out_valid, 1);
    chk("t4_data_first", out_data, 8'h41);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_data_second", out_data, 8'h42);
    @(negedge clk);
    chk("t4_data_third", out_data, 8'h43);
    @(negedge clk);
    chk("t4_valid_end", out_valid, 0);
    chk("t4_reads", rd_cnt - rd0, 4);

    // ---- asynchronous reset mid-stream ----------------------------------------
    load(35, 8, 8'h50);
    repeat (4) @(negedge clk);
    chk("t5_pre_valid", out_valid, 1);
    chk("t5_pre_data", out_data, 8'h52);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_data", out_data, 0);
    chk("t5_async_read", fifo_read, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rel_valid", out_valid, 0);
    @(negedge clk);
    chk("t5_resume_valid", out_valid, 1);
    chk("t5_resume_data", out_data, 8'h54);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("t5_data", out_data, 8'h54 + i);
    end
    @(negedge clk);
    chk("t5_valid_end", out_valid, 0);

`ifdef FIFO_STREAM_READER_CNT_EN
    // ---- transfer counter -----------------------------------------------------
    // 0x54..0x57 were transferred since the last reset.
    chk("cnt_after_reset", word_count, 4);
    load(43, 66, 8'h60);
    repeat (70) @(negedge clk);
    chk("cnt_70", word_count, 70);
    chk("cnt_drained", out_valid, 0);

    out_ready = 1'b0;
    force dut.word_count_q = 16'hfffd;
    @(negedge clk);
    release dut.word_count_q;
    load(109, 4, 8'h70);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("cnt_preset", word_count, 16'hfffd);
    @(negedge clk);
    chk("cnt_fffe", word_count, 16'hfffe);
    @(negedge clk);
    chk("cnt_ffff", word_count, 16'hffff);
    @(negedge clk);
    chk("cnt_wrap0", word_count, 16'h0000);
    @(negedge clk);
    chk("cnt_wrap1", word_count, 16'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
